// File: rtl/sha512_core_io_pkg.sv
// Shared constants and types for the SHA-512 core-side I/O endpoint.
package sha512_core_io_pkg;

   // MSB of the block-operation flag field carried with each block
   localparam int BLK_OP_MSB_DEF = 3;
   // 32-bit words per serialized 512-bit result
   localparam int OUT_WORDS_DEF  = 16;
   // 64-bit words per input block
   localparam int BLK_WORDS      = 16;
   // 64-bit words per result
   localparam int RES_WORDS      = 8;

   // Output serializer state
   typedef enum logic {
      SER_IDLE = 1'b0,
      SER_SEND = 1'b1
   } ser_state_t;

endpackage

// File: rtl/sha512_core_out_ser.sv
// Result serializer: 8x64 result RAM written by the datapath, then streamed
// out as sixteen 32-bit words (low half first) under core_rd_en pops.
module sha512_core_out_ser
   import sha512_core_io_pkg::*;
#(
   parameter int OUT_WORDS = OUT_WORDS_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        res_wr_en,
   input  logic [2:0]  res_addr,
   input  logic [63:0] res_din,
   input  logic        res_ctx,
   input  logic        res_seq,
   input  logic        res_commit,
   input  logic        core_rd_en,
   output logic [31:0] core_out,
   output logic        core_out_ready,
   output logic        core_out_start,
   output logic        core_out_ctx_num,
   output logic        core_out_seq_num,
   output logic        viol,
   output ser_state_t  state
);

   // Handshake: core_out is valid while core_out_ready=1; a word is consumed
   // in any cycle where core_out_ready=1 and core_rd_en=1 at the clock edge.

   localparam logic [3:0] LAST_CNT = 4'(OUT_WORDS - 1);

   ser_state_t  state_nxt;
   logic [63:0] res_mem [RES_WORDS];
   logic [3:0]  cnt;
   logic        ctx_q;
   logic        seq_q;
   logic [63:0] cur_word;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= SER_IDLE;
      else     state <= state_nxt;
   end

   // Next-state: commit starts a send, the last pop ends it
   always_comb begin
      state_nxt = state;
      case (state)
         SER_IDLE: if (res_commit) state_nxt = SER_SEND;
         SER_SEND: if (core_rd_en && cnt == LAST_CNT) state_nxt = SER_IDLE;
         default:  state_nxt = SER_IDLE;
      endcase
   end

   // Result RAM: only writable while the output buffer is not busy
   always_ff @(posedge clk) begin
      if (state == SER_IDLE && res_wr_en) res_mem[res_addr] <= res_din;
   end

   // Word counter and result tags
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         ctx_q <= 1'b0;
         seq_q <= 1'b0;
      end else if (state == SER_IDLE && res_commit) begin
         cnt   <= '0;
         ctx_q <= res_ctx;
         seq_q <= res_seq;
      end else if (state == SER_SEND && core_rd_en) begin
         cnt   <= cnt + 4'd1;
      end
   end

   // Outputs: combinational read so the engine can pop every cycle
   always_comb begin
      cur_word         = res_mem[cnt[3:1]];
      core_out         = '0;
      core_out_ready   = 1'b0;
      core_out_start   = 1'b0;
      core_out_ctx_num = ctx_q;
      core_out_seq_num = seq_q;
      viol             = 1'b0;
      case (state)
         SER_IDLE: begin
            viol = core_rd_en;
         end
         SER_SEND: begin
            core_out_ready = 1'b1;
            core_out       = cnt[0] ? cur_word[63:32] : cur_word[31:0];
            core_out_start = (cnt == 4'd0);
            viol           = res_wr_en | res_commit;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/sha512_core_io.sv
// Core-side endpoint: two input block buffers with arrival-order presentation
// to the SHA-512 datapath, plus the result serializer toward the engine.
module sha512_core_io
   import sha512_core_io_pkg::*;
#(
   parameter int BLK_OP_MSB = BLK_OP_MSB_DEF,
   parameter int OUT_WORDS  = OUT_WORDS_DEF
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                wr_en,
   input  logic [63:0]         core_in,
   input  logic [3:0]          wr_addr,
   input  logic                input_seq,
   input  logic                input_ctx,
   input  logic [BLK_OP_MSB:0] input_blk_op,
   input  logic                set_input_ready,
   output logic                ready0,
   output logic                ready1,
   output logic                blk_valid,
   output logic                blk_seq,
   output logic                blk_ctx,
   output logic [BLK_OP_MSB:0] blk_op,
   input  logic [3:0]          blk_rd_addr,
   output logic [63:0]         blk_dout,
   input  logic                blk_done,
   input  logic                res_wr_en,
   input  logic [2:0]          res_addr,
   input  logic [63:0]         res_din,
   input  logic                res_ctx,
   input  logic                res_seq,
   input  logic                res_commit,
   output logic                res_full,
   output logic [31:0]         core_out,
   output logic                core_out_ready,
   output logic                core_out_start,
   output logic                core_out_ctx_num,
   output logic                core_out_seq_num,
   input  logic                core_rd_en,
   output logic                err
);

   logic [63:0]         in_mem [2*BLK_WORDS];
   logic [1:0]          full;
   logic                oldest;
   logic [1:0]          ctx_q;
   logic [BLK_OP_MSB:0] op_q [2];
   logic                pres_seq;
   logic                wr_ok;
   logic                fill;
   logic                free;
   logic                in_viol;
   logic                ser_viol;
   ser_state_t          ser_state;

   // Presentation select and per-cycle buffer events
   always_comb begin
      pres_seq = (full == 2'b11) ? oldest : full[1];
      wr_ok    = wr_en & ~full[input_seq];
      fill     = wr_en & set_input_ready & ~full[input_seq];
      free     = blk_done & (|full);
      in_viol  = (wr_en & full[input_seq]) | (blk_done & ~(|full));
   end

   // Buffer occupancy and fill order; oldest names the earlier-filled buffer
   always_ff @(posedge CLK) begin
      if (RST) begin
         full   <= 2'b00;
         oldest <= 1'b0;
      end else begin
         if (free) full[pres_seq] <= 1'b0;
         if (fill) begin
            full[input_seq] <= 1'b1;
            // The other buffer is older only if it stays full this cycle
            if (full[~input_seq] && !(free && pres_seq == ~input_seq))
               oldest <= ~input_seq;
            else
               oldest <= input_seq;
         end
      end
   end

   // Per-buffer block tags captured when the buffer is marked full
   always_ff @(posedge CLK) begin
      if (fill) begin
         ctx_q[input_seq] <= input_ctx;
         op_q[input_seq]  <= input_blk_op;
      end
   end

   // Input block memory and registered datapath read port
   always_ff @(posedge CLK) begin
      if (wr_ok) in_mem[{input_seq, wr_addr}] <= core_in;
      blk_dout <= in_mem[{pres_seq, blk_rd_addr}];
   end

   // Sticky protocol-violation flag
   always_ff @(posedge CLK) begin
      if (RST)                      err <= 1'b0;
      else if (in_viol || ser_viol) err <= 1'b1;
   end

   // Status outputs
   always_comb begin
      ready0    = ~full[0];
      ready1    = ~full[1];
      blk_valid = |full;
      blk_seq   = pres_seq;
      blk_ctx   = ctx_q[pres_seq];
      blk_op    = op_q[pres_seq];
      res_full  = (ser_state == SER_SEND);
   end

   sha512_core_out_ser #(
      .OUT_WORDS (OUT_WORDS)
   ) u_ser (
      .clk              (CLK),
      .rst              (RST),
      .res_wr_en        (res_wr_en),
      .res_addr         (res_addr),
      .res_din          (res_din),
      .res_ctx          (res_ctx),
      .res_seq          (res_seq),
      .res_commit       (res_commit),
      .core_rd_en       (core_rd_en),
      .core_out         (core_out),
      .core_out_ready   (core_out_ready),
      .core_out_start   (core_out_start),
      .core_out_ctx_num (core_out_ctx_num),
      .core_out_seq_num (core_out_seq_num),
      .viol             (ser_viol),
      .state            (ser_state)
   );

endmodule

// File: tb/tb_sha512_core_io.sv
// Directed self-checking bench for sha512_core_io.
module tb_sha512_core_io;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        wr_en = 1'b0;
   logic [63:0] core_in = '0;
   logic [3:0]  wr_addr = '0;
   logic        input_seq = 1'b0;
   logic        input_ctx = 1'b0;
   logic [3:0]  input_blk_op = '0;
   logic        set_input_ready = 1'b0;
   logic        ready0, ready1, blk_valid, blk_seq, blk_ctx;
   logic [3:0]  blk_op;
   logic [3:0]  blk_rd_addr = '0;
   logic [63:0] blk_dout;
   logic        blk_done = 1'b0;
   logic        res_wr_en = 1'b0;
   logic [2:0]  res_addr = '0;
   logic [63:0] res_din = '0;
   logic        res_ctx = 1'b0;
   logic        res_seq = 1'b0;
   logic        res_commit = 1'b0;
   logic        res_full;
   logic [31:0] core_out;
   logic        core_out_ready, core_out_start, core_out_ctx_num, core_out_seq_num;
   logic        core_rd_en = 1'b0;
   logic        err;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_w;

   sha512_core_io dut (
      .CLK(CLK), .RST(RST), .wr_en(wr_en), .core_in(core_in), .wr_addr(wr_addr),
      .input_seq(input_seq), .input_ctx(input_ctx), .input_blk_op(input_blk_op),
      .set_input_ready(set_input_ready), .ready0(ready0), .ready1(ready1),
      .blk_valid(blk_valid), .blk_seq(blk_seq), .blk_ctx(blk_ctx), .blk_op(blk_op),
      .blk_rd_addr(blk_rd_addr), .blk_dout(blk_dout), .blk_done(blk_done),
      .res_wr_en(res_wr_en), .res_addr(res_addr), .res_din(res_din),
      .res_ctx(res_ctx), .res_seq(res_seq), .res_commit(res_commit),
      .res_full(res_full), .core_out(core_out), .core_out_ready(core_out_ready),
      .core_out_start(core_out_start), .core_out_ctx_num(core_out_ctx_num),
      .core_out_seq_num(core_out_seq_num), .core_rd_en(core_rd_en), .err(err)
   );

   // Clock
   always #5 CLK = ~CLK;

   // Inputs change and outputs are sampled 1ns after each rising edge
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      tick();
      RST = 1'b0;
   endtask

   task automatic fill_block(input logic seq, input logic [63:0] base,
                             input logic ctx, input logic [3:0] op);
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; input_seq = seq; wr_addr = 4'(i); core_in = base + 64'(i);
         set_input_ready = (i == 15); input_ctx = ctx; input_blk_op = op;
         tick();
      end
      wr_en = 1'b0; set_input_ready = 1'b0;
   endtask

   task automatic pulse_done();
      blk_done = 1'b1;
      tick();
      blk_done = 1'b0;
   endtask

   task automatic load_result(input logic [31:0] lo_base, input logic [31:0] hi_base);
      for (int k = 0; k < 8; k++) begin
         res_wr_en = 1'b1; res_addr = 3'(k);
         res_din = {hi_base + 32'(k), lo_base + 32'(k)};
         tick();
      end
      res_wr_en = 1'b0;
   endtask

   task automatic commit(input logic ctx, input logic seq);
      res_commit = 1'b1; res_ctx = ctx; res_seq = seq;
      tick();
      res_commit = 1'b0;
   endtask

   task automatic push_expected(input logic [31:0] lo_base, input logic [31:0] hi_base);
      for (int k = 0; k < 8; k++) begin
         exp_q.push_back(lo_base + 32'(k));
         exp_q.push_back(hi_base + 32'(k));
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL rst_ready0 got %0b exp 1", ready0); end
      checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL rst_ready1 got %0b exp 1", ready1); end
      checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL rst_blk_valid got %0b exp 0", blk_valid); end
      checks++; if (res_full !== 1'b0) begin errors++; $display("FAIL rst_res_full got %0b exp 0", res_full); end
      checks++; if (core_out_ready !== 1'b0) begin errors++; $display("FAIL rst_out_ready got %0b exp 0", core_out_ready); end
      checks++; if (core_out_start !== 1'b0) begin errors++; $display("FAIL rst_out_start got %0b exp 0", core_out_start); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %0b exp 0", err); end
   endtask

   task automatic test_single_block();
      fill_block(1'b0, 64'h1000, 1'b1, 4'd3);
      checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL single_ready0 got %0b exp 0", ready0); end
      checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL single_ready1 got %0b exp 1", ready1); end
      checks++; if (blk_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b exp 1", blk_valid); end
      checks++; if (blk_seq !== 1'b0) begin errors++; $display("FAIL single_seq got %0b exp 0", blk_seq); end
      checks++; if (blk_ctx !== 1'b1) begin errors++; $display("FAIL single_ctx got %0b exp 1", blk_ctx); end
      checks++; if (blk_op !== 4'd3) begin errors++; $display("FAIL single_op got %0d exp 3", blk_op); end
      blk_rd_addr = 4'd5;
      tick();
      checks++; if (blk_dout !== 64'h1005) begin errors++; $display("FAIL single_dout got %h exp %h", blk_dout, 64'h1005); end
      pulse_done();
      checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL single_freed_valid got %0b exp 0", blk_valid); end
      checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL single_freed_ready0 got %0b exp 1", ready0); end
   endtask

   task automatic test_order();
      fill_block(1'b1, 64'h2000, 1'b0, 4'd1);
      fill_block(1'b0, 64'h3000, 1'b1, 4'd2);
      checks++; if (blk_seq !== 1'b1) begin errors++; $display("FAIL order_first_seq got %0b exp 1", blk_seq); end
      checks++; if (blk_ctx !== 1'b0) begin errors++; $display("FAIL order_first_ctx got %0b exp 0", blk_ctx); end
      checks++; if (blk_op !== 4'd1) begin errors++; $display("FAIL order_first_op got %0d exp 1", blk_op); end
      blk_rd_addr = 4'd3;
      tick();
      checks++; if (blk_dout !== 64'h2003) begin errors++; $display("FAIL order_first_dout got %h exp %h", blk_dout, 64'h2003); end
      pulse_done();
      checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL order_ready1 got %0b exp 1", ready1); end
      checks++; if (blk_valid !== 1'b1) begin errors++; $display("FAIL order_still_valid got %0b exp 1", blk_valid); end
      checks++; if (blk_seq !== 1'b0) begin errors++; $display("FAIL order_second_seq got %0b exp 0", blk_seq); end
      checks++; if (blk_ctx !== 1'b1) begin errors++; $display("FAIL order_second_ctx got %0b exp 1", blk_ctx); end
      blk_rd_addr = 4'd15;
      tick();
      checks++; if (blk_dout !== 64'h300F) begin errors++; $display("FAIL order_second_dout got %h exp %h", blk_dout, 64'h300F); end
      pulse_done();
      checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL order_empty_valid got %0b exp 0", blk_valid); end
      checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL order_ready0 got %0b exp 1", ready0); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL order_err got %0b exp 0", err); end
   endtask

   task automatic test_output_burst();
      load_result(32'hA000, 32'hB000);
      checks++; if (res_full !== 1'b0) begin errors++; $display("FAIL burst_pre_full got %0b exp 0", res_full); end
      commit(1'b0, 1'b1);
      push_expected(32'hA000, 32'hB000);
      checks++; if (res_full !== 1'b1) begin errors++; $display("FAIL burst_full got %0b exp 1", res_full); end
      for (int i = 0; i < 16; i++) begin
         exp_w = exp_q.pop_front();
         checks++; if (core_out_ready !== 1'b1) begin errors++; $display("FAIL burst_ready[%0d] got %0b exp 1", i, core_out_ready); end
         checks++; if (core_out !== exp_w) begin errors++; $display("FAIL burst_word[%0d] got %h exp %h", i, core_out, exp_w); end
         checks++; if (core_out_start !== (i == 0)) begin errors++; $display("FAIL burst_start[%0d] got %0b exp %0b", i, core_out_start, (i == 0)); end
         checks++; if ({core_out_ctx_num, core_out_seq_num} !== 2'b01) begin errors++; $display("FAIL burst_tags[%0d] got %b exp 01", i, {core_out_ctx_num, core_out_seq_num}); end
         checks++; if (res_full !== 1'b1) begin errors++; $display("FAIL burst_hold_full[%0d] got %0b exp 1", i, res_full); end
         core_rd_en = 1'b1;
         tick();
      end
      core_rd_en = 1'b0;
      checks++; if (res_full !== 1'b0) begin errors++; $display("FAIL burst_end_full got %0b exp 0", res_full); end
      checks++; if (core_out_ready !== 1'b0) begin errors++; $display("FAIL burst_end_ready got %0b exp 0", core_out_ready); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL burst_err got %0b exp 0", err); end
   endtask

   task automatic test_output_gaps();
      load_result(32'hC000, 32'hD000);
      commit(1'b1, 1'b0);
      push_expected(32'hC000, 32'hD000);
      for (int i = 0; i < 16; i++) begin
         exp_w = exp_q.pop_front();
         for (int g = 0; g < 3; g++) begin
            checks++; if (core_out !== exp_w) begin errors++; $display("FAIL gap_word[%0d.%0d] got %h exp %h", i, g, core_out, exp_w); end
            checks++; if (core_out_start !== (i == 0)) begin errors++; $display("FAIL gap_start[%0d.%0d] got %0b exp %0b", i, g, core_out_start, (i == 0)); end
            core_rd_en = (g == 2);
            tick();
         end
         core_rd_en = 1'b0;
      end
      checks++; if ({core_out_ctx_num, core_out_seq_num} !== 2'b10) begin errors++; $display("FAIL gap_tags got %b exp 10", {core_out_ctx_num, core_out_seq_num}); end
      checks++; if (res_full !== 1'b0) begin errors++; $display("FAIL gap_end_full got %0b exp 0", res_full); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL gap_err got %0b exp 0", err); end
   endtask

   task automatic test_violations();
      // Write to a full buffer
      do_reset();
      fill_block(1'b0, 64'h4000, 1'b0, 4'd0);
      wr_en = 1'b1; input_seq = 1'b0; wr_addr = 4'd2; core_in = 64'hDEAD_BEEF;
      tick();
      wr_en = 1'b0;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL viol_wr_err got %0b exp 1", err); end
      blk_rd_addr = 4'd2;
      tick();
      checks++; if (blk_dout !== 64'h4002) begin errors++; $display("FAIL viol_wr_mem got %h exp %h", blk_dout, 64'h4002); end
      // set_input_ready on the already-full buffer keeps the original tags
      wr_en = 1'b1; set_input_ready = 1'b1; input_ctx = 1'b1; input_blk_op = 4'd9;
      tick();
      wr_en = 1'b0; set_input_ready = 1'b0;
      checks++; if (blk_ctx !== 1'b0 || blk_op !== 4'd0) begin errors++; $display("FAIL viol_set_tags got %0b/%0d exp 0/0", blk_ctx, blk_op); end
      // Result write during SEND
      do_reset();
      commit(1'b0, 1'b0);
      res_wr_en = 1'b1; res_addr = 3'd0; res_din = '1;
      tick();
      res_wr_en = 1'b0;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL viol_res_err got %0b exp 1", err); end
      checks++; if (core_out !== 32'hC000) begin errors++; $display("FAIL viol_res_mem got %h exp %h", core_out, 32'hC000); end
      // blk_done with no presented block
      do_reset();
      pulse_done();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL viol_done_err got %0b exp 1", err); end
      checks++; if (ready0 !== 1'b1 || ready1 !== 1'b1) begin errors++; $display("FAIL viol_done_ready got %b exp 11", {ready0, ready1}); end
      // core_rd_en while idle, and stickiness over idle cycles
      do_reset();
      core_rd_en = 1'b1;
      tick();
      core_rd_en = 1'b0;
      tick(); tick(); tick();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL viol_sticky_err got %0b exp 1", err); end
      checks++; if (core_out_ready !== 1'b0) begin errors++; $display("FAIL viol_idle_ready got %0b exp 0", core_out_ready); end
   endtask

   task automatic test_reset_midway();
      do_reset();
      fill_block(1'b0, 64'h5000, 1'b0, 4'd1);
      fill_block(1'b1, 64'h6000, 1'b1, 4'd2);
      commit(1'b1, 1'b1);
      for (int i = 0; i < 7; i++) begin
         core_rd_en = 1'b1;
         tick();
      end
      core_rd_en = 1'b0;
      checks++; if (core_out !== 32'hD003) begin errors++; $display("FAIL mid_word7 got %h exp %h", core_out, 32'hD003); end
      // Raise err so reset clearing it is observable
      pulse_done();
      wr_en = 1'b1; input_seq = 1'b1; wr_addr = 4'd0; core_in = 64'h1;
      tick();
      wr_en = 1'b0;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL mid_pre_err got %0b exp 1", err); end
      do_reset();
      checks++; if (ready0 !== 1'b1 || ready1 !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 11", {ready0, ready1}); end
      checks++; if (core_out_ready !== 1'b0) begin errors++; $display("FAIL mid_out_ready got %0b exp 0", core_out_ready); end
      checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %0b exp 0", blk_valid); end
      checks++; if (res_full !== 1'b0) begin errors++; $display("FAIL mid_full got %0b exp 0", res_full); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err got %0b exp 0", err); end
   endtask

   initial begin
      #2;
      test_reset();
      test_single_block();
      test_order();
      test_output_burst();
      test_output_gaps();
      test_violations();
      test_reset_midway();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
